// File: rtl/wb_stage_multi.sv
// ---------------------------------------------------------------------------
// wb_stage_multi
//   Writeback stage for a LANES-wide in-order pipeline. It latches one group
//   of up to LANES instructions from MEM and does the following:
//     - masks the group at the oldest excepting lane
//     - merges byte strobes of lanes that write the same destination
//     - writes the register file once per group
//     - pulses a flush/EPC to the front end when an exception retires
//     - drives the MEM->ID bypass while the group is held
//     - emits the debug trace one lane per cycle; the stage stalls until the
//       trace is drained
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   ws_allowin          stage can take a group this cycle
//   ms_to_ws_valid      MEM offers a group
//   ms_lane_valid       per-lane instruction present
//   ms_wstrb/dest/result/pc/ex
//                       per-lane payload (4b strobe, 5b dest, DW data, DW pc,
//                       exception flag)
//   rf_we/waddr/wdata   per-lane regfile write port, active on group entry only
//   ws_to_ds_*          bypass strobes/dest/data, held while the group stays
//   ws_ex_flush/ws_epc  one-cycle exception retire pulse and its PC
//   debug_wb_*          trace beat (pc, byte enables, dest, data)
//
// Trace FSM
//   state | meaning
//   IDLE  | no group held, stage empty
//   DRAIN | group held; one reported lane is traced per cycle
// ---------------------------------------------------------------------------
module wb_stage_multi #(
  parameter int LANES = 2,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ws_allowin,
  input  logic                ms_to_ws_valid,
  input  logic [LANES-1:0]    ms_lane_valid,
  input  logic [4*LANES-1:0]  ms_wstrb,
  input  logic [5*LANES-1:0]  ms_dest,
  input  logic [DW*LANES-1:0] ms_result,
  input  logic [DW*LANES-1:0] ms_pc,
  input  logic [LANES-1:0]    ms_ex,
  output logic [4*LANES-1:0]  rf_we,
  output logic [5*LANES-1:0]  rf_waddr,
  output logic [DW*LANES-1:0] rf_wdata,
  output logic [4*LANES-1:0]  ws_to_ds_we,
  output logic [5*LANES-1:0]  ws_to_ds_dest,
  output logic [DW*LANES-1:0] ws_to_ds_result,
  output logic                ws_ex_flush,
  output logic [DW-1:0]       ws_epc,
  output logic [DW-1:0]       debug_wb_pc,
  output logic [3:0]          debug_wb_rf_wen,
  output logic [4:0]          debug_wb_rf_wnum,
  output logic [DW-1:0]       debug_wb_rf_wdata
);

  // The trace index may step one past the last lane, so it needs LANES+1 codes.
  localparam int IXW = $clog2(LANES + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [LANES-1:0]    lv_q;
  logic [LANES-1:0]    ex_q;
  logic [4*LANES-1:0]  strb_q;
  logic [5*LANES-1:0]  dest_q;
  logic [DW*LANES-1:0] res_q;
  logic [DW*LANES-1:0] pc_q;
  logic                first_q;
  logic [IXW-1:0]      idx_q;

  logic                ws_valid;
  logic                live;
  logic                accept;
  logic                ws_ready_go;
  logic [LANES-1:0]    commit;
  logic [LANES-1:0]    report;
  logic                has_ex;
  logic [DW-1:0]       epc;
  logic [4*LANES-1:0]  strb_raw;
  logic [4*LANES-1:0]  strb_fin;
  logic                beat;
  logic                more;
  logic [IXW-1:0]      idx_nxt;
  logic [DW-1:0]       tr_pc;
  logic [3:0]          tr_wen;
  logic [4:0]          tr_wnum;
  logic [DW-1:0]       tr_data;

  assign ws_valid = (state == DRAIN);
  // Outputs go quiet while reset is asserted, so a trace beat that is being
  // abandoned is never shown to the trace collector.
  assign live        = ws_valid && !reset;
  assign ws_ready_go = live && !more;
  assign accept      = ms_to_ws_valid && ws_allowin && !reset;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DRAIN;
      DRAIN:   if (ws_ready_go && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- payload, entry flag, trace index ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      lv_q    <= '0;
      ex_q    <= '0;
      strb_q  <= '0;
      dest_q  <= '0;
      res_q   <= '0;
      pc_q    <= '0;
      first_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      first_q <= accept;
      if (accept) begin
        lv_q   <= ms_lane_valid;
        ex_q   <= ms_ex;
        strb_q <= ms_wstrb;
        dest_q <= ms_dest;
        res_q  <= ms_result;
        pc_q   <= ms_pc;
        idx_q  <= '0;
      end else if (beat) begin
        idx_q  <= idx_nxt;
      end
    end
  end

  // ---------------- exception masking ----------------
  // has_ex flips on at the oldest excepting lane; everything from there on is
  // uncommitted, and only that lane itself is still reported.
  always_comb begin
    commit = '0;
    report = '0;
    has_ex = 1'b0;
    epc    = '0;
    for (int i = 0; i < LANES; i++) begin
      report[i] = lv_q[i] && !has_ex;
      commit[i] = lv_q[i] && !ex_q[i] && !has_ex;
      if (lv_q[i] && ex_q[i] && !has_ex) begin
        has_ex = 1'b1;
        epc    = pc_q[DW*i +: DW];
      end
    end
  end

  // ---------------- strobe masking and same-dest merge ----------------
  // strb_raw is already zero for dest 0 and uncommitted lanes, so comparing
  // destinations alone is enough when a younger lane shadows an older one.
  always_comb begin
    strb_raw = '0;
    strb_fin = '0;
    for (int i = 0; i < LANES; i++) begin
      if (commit[i] && (dest_q[5*i +: 5] != 5'd0)) begin
        strb_raw[4*i +: 4] = strb_q[4*i +: 4];
      end
    end
    for (int i = 0; i < LANES; i++) begin
      strb_fin[4*i +: 4] = strb_raw[4*i +: 4];
      for (int j = 0; j < LANES; j++) begin
        if ((j > i) && (dest_q[5*j +: 5] == dest_q[5*i +: 5])) begin
          strb_fin[4*i +: 4] = strb_fin[4*i +: 4] & ~strb_raw[4*j +: 4];
        end
      end
    end
  end

  // ---------------- trace lane select ----------------
  // idx_q is a floor: the current beat is the lowest reported lane at or
  // above it. more = another reported lane remains after this one.
  always_comb begin
    beat    = 1'b0;
    more    = 1'b0;
    idx_nxt = idx_q;
    tr_pc   = '0;
    tr_wen  = '0;
    tr_wnum = '0;
    tr_data = '0;
    if (live) begin
      for (int i = 0; i < LANES; i++) begin
        if (report[i] && (IXW'(i) >= idx_q)) begin
          if (!beat) begin
            beat    = 1'b1;
            idx_nxt = IXW'(i + 1);
            tr_pc   = pc_q[DW*i +: DW];
            tr_wen  = strb_fin[4*i +: 4];
            tr_wnum = dest_q[5*i +: 5];
            tr_data = res_q[DW*i +: DW];
          end else begin
            more = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ws_allowin        = !live || ws_ready_go;
    rf_we             = '0;
    rf_waddr          = '0;
    rf_wdata          = '0;
    ws_to_ds_we       = '0;
    ws_to_ds_dest     = '0;
    ws_to_ds_result   = '0;
    ws_ex_flush       = 1'b0;
    ws_epc            = '0;
    debug_wb_pc       = '0;
    debug_wb_rf_wen   = '0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    if (live) begin
      rf_waddr          = dest_q;
      rf_wdata          = res_q;
      ws_to_ds_we       = strb_fin;
      ws_to_ds_dest     = dest_q;
      ws_to_ds_result   = res_q;
      debug_wb_pc       = tr_pc;
      debug_wb_rf_wen   = tr_wen;
      debug_wb_rf_wnum  = tr_wnum;
      debug_wb_rf_wdata = tr_data;
      // The regfile write and the flush happen once, on the entry cycle.
      if (first_q) begin
        rf_we       = strb_fin;
        ws_ex_flush = has_ex;
        ws_epc      = has_ex ? epc : '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_multi.sv
module tb_wb_stage_multi;
  localparam int L  = 2;
  localparam int DW = 32;

  typedef struct packed {
    logic [L-1:0]    lv;
    logic [L-1:0]    ex;
    logic [4*L-1:0]  strb;
    logic [5*L-1:0]  dest;
    logic [DW*L-1:0] res;
    logic [DW*L-1:0] pc;
  } grp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            ws_allowin;
  logic            ms_to_ws_valid;
  logic [L-1:0]    ms_lane_valid;
  logic [4*L-1:0]  ms_wstrb;
  logic [5*L-1:0]  ms_dest;
  logic [DW*L-1:0] ms_result;
  logic [DW*L-1:0] ms_pc;
  logic [L-1:0]    ms_ex;
  logic [4*L-1:0]  rf_we;
  logic [5*L-1:0]  rf_waddr;
  logic [DW*L-1:0] rf_wdata;
  logic [4*L-1:0]  ws_to_ds_we;
  logic [5*L-1:0]  ws_to_ds_dest;
  logic [DW*L-1:0] ws_to_ds_result;
  logic            ws_ex_flush;
  logic [DW-1:0]   ws_epc;
  logic [DW-1:0]   debug_wb_pc;
  logic [3:0]      debug_wb_rf_wen;
  logic [4:0]      debug_wb_rf_wnum;
  logic [DW-1:0]   debug_wb_rf_wdata;

  wb_stage_multi #(.LANES(L), .DW(DW)) dut (
    .clk(clk), .reset(reset), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_lane_valid(ms_lane_valid),
    .ms_wstrb(ms_wstrb), .ms_dest(ms_dest), .ms_result(ms_result),
    .ms_pc(ms_pc), .ms_ex(ms_ex),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ws_to_ds_we(ws_to_ds_we), .ws_to_ds_dest(ws_to_ds_dest),
    .ws_to_ds_result(ws_to_ds_result),
    .ws_ex_flush(ws_ex_flush), .ws_epc(ws_epc),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observations of the DUT, used by the literal checks.
  logic [DW-1:0] rf_m [32];
  logic [DW-1:0] trace_log [$];
  int            acc_cyc [$];
  int            flush_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int k_of(grp_t g);
    for (int i = 0; i < L; i++) if (g.lv[i] && g.ex[i]) return i;
    return L;
  endfunction

  // Bytes lane i really writes: committed, nonzero dest, minus any bytes a
  // younger committed lane writes to the same register.
  function automatic logic [3:0] wen_of(grp_t g, int i);
    int k;
    logic [3:0] w;
    k = k_of(g);
    if (!g.lv[i] || i >= k || g.dest[5*i +: 5] == 5'd0) return 4'h0;
    w = g.strb[4*i +: 4];
    for (int j = i + 1; j < k; j++)
      if (g.lv[j] && g.dest[5*j +: 5] == g.dest[5*i +: 5]) w = w & ~g.strb[4*j +: 4];
    return w;
  endfunction

  grp_t mg;
  logic m_valid = 1'b0;
  logic m_first = 1'b0;
  int   m_pos = 0;
  int   beats [$];

  initial begin : cmp
    logic            e_allow, last, acc;
    logic [4*L-1:0]  ewe;
    logic [DW-1:0]   e_pc, e_data;
    logic [3:0]      e_wen;
    logic [4:0]      e_num;
    int              k, b;
    for (int r = 0; r < 32; r++) rf_m[r] = '0;
    forever begin
      @(negedge clk);
      ewe = '0; e_pc = '0; e_data = '0; e_wen = '0; e_num = '0; last = 1'b1;
      if (reset || !m_valid) begin
        e_allow = 1'b1;
        chk("idle_rf_we", rf_we, '0);
        chk("idle_byp_we", ws_to_ds_we, '0);
        chk("idle_byp_dest", ws_to_ds_dest, '0);
        chk("idle_byp_res", ws_to_ds_result, '0);
        chk("idle_flush", {ws_ex_flush, ws_epc}, '0);
      end else begin
        k = k_of(mg);
        last = (beats.size() == 0) || (m_pos == beats.size() - 1);
        e_allow = last;
        for (int i = 0; i < L; i++) ewe[4*i +: 4] = wen_of(mg, i);
        chk("rf_we", rf_we, m_first ? ewe : '0);
        for (int i = 0; i < L; i++)
          if (m_first && ewe[4*i +: 4] != 4'h0)
            chk("rf_waddr_wdata", {rf_waddr[5*i +: 5], rf_wdata[DW*i +: DW]},
                {mg.dest[5*i +: 5], mg.res[DW*i +: DW]});
        chk("byp_we", ws_to_ds_we, ewe);
        chk("byp_dest", ws_to_ds_dest, mg.dest);
        chk("byp_res", ws_to_ds_result, mg.res);
        chk("flush", {ws_ex_flush, ws_epc},
            (m_first && k < L) ? {1'b1, mg.pc[DW*k +: DW]} : '0);
        if (beats.size() > 0) begin
          b = beats[m_pos];
          e_pc = mg.pc[DW*b +: DW]; e_wen = wen_of(mg, b);
          e_num = mg.dest[5*b +: 5]; e_data = mg.res[DW*b +: DW];
        end
      end
      chk("allowin", ws_allowin, e_allow);
      chk("trace", {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata},
          {e_pc, e_wen, e_num, e_data});
      // Observed side effects for the literal checks.
      for (int i = 0; i < L; i++)
        for (int by = 0; by < 4; by++)
          if (rf_we[4*i + by]) rf_m[rf_waddr[5*i +: 5]][8*by +: 8] = rf_wdata[DW*i + 8*by +: 8];
      if (debug_wb_pc != '0) trace_log.push_back(debug_wb_pc);
      if (ws_ex_flush) flush_cnt++;

      @(posedge clk);
      if (reset) begin
        m_valid = 1'b0; m_first = 1'b0;
      end else begin
        acc = ms_to_ws_valid && e_allow;
        if (m_valid && last) m_valid = 1'b0;
        else if (m_valid) m_pos++;
        if (acc) begin
          mg = '{lv: ms_lane_valid, ex: ms_ex, strb: ms_wstrb, dest: ms_dest,
                 res: ms_result, pc: ms_pc};
          beats.delete();
          k = k_of(mg);
          for (int i = 0; i < L; i++) if (mg.lv[i] && i <= k) beats.push_back(i);
          m_valid = 1'b1; m_pos = 0;
        end
        m_first = acc;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic send(input grp_t g);
    logic a;
    int n;
    n = 0; a = 1'b0;
    ms_lane_valid = g.lv; ms_ex = g.ex; ms_wstrb = g.strb;
    ms_dest = g.dest; ms_result = g.res; ms_pc = g.pc;
    ms_to_ws_valid = 1'b1;
    while (!a && n < 50) begin
      @(negedge clk); a = ws_allowin;
      @(posedge clk); n++;
      if (a) acc_cyc.push_back(cyc);
    end
    #1 ms_to_ws_valid = 1'b0;
    if (!a) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: group not accepted within 50 cycles");
    end
  endtask

  function automatic grp_t mk(logic [1:0] lv, logic [1:0] ex, logic [7:0] strb,
                              logic [4:0] d1, logic [4:0] d0,
                              logic [31:0] r1, logic [31:0] r0,
                              logic [31:0] p1, logic [31:0] p0);
    grp_t g;
    g.lv = lv; g.ex = ex; g.strb = strb; g.dest = {d1, d0};
    g.res = {r1, r0}; g.pc = {p1, p0};
    return g;
  endfunction

  initial begin : drv
    reset = 1'b1; ms_to_ws_valid = 1'b0; ms_lane_valid = '0; ms_ex = '0;
    ms_wstrb = '0; ms_dest = '0; ms_result = '0; ms_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_allowin", ws_allowin, 1'b1);
    chk("rst_outs", {rf_we, ws_ex_flush, debug_wb_pc, debug_wb_rf_wen}, '0);
    sync(); reset = 1'b0;
    @(negedge clk);
    chk("post_rst_allowin", ws_allowin, 1'b1);
    sync();

    // Two independent lanes.
    send(mk(2'b11, 2'b00, 8'hFF, 5'd4, 5'd3, 32'h22, 32'h11, 32'h104, 32'h100));
    @(negedge clk);
    chk("A_we_c1", rf_we, 8'hFF);
    chk("A_allowin_c1", ws_allowin, 1'b0);
    chk("A_trace_c1", debug_wb_pc, 32'h100);
    @(negedge clk);
    chk("A_we_c2", rf_we, 8'h00);
    chk("A_trace_c2", debug_wb_pc, 32'h104);
    chk("A_allowin_c2", ws_allowin, 1'b1);
    sync();

    // Same destination: younger bytes win.
    send(mk(2'b11, 2'b00, 8'h3F, 5'd5, 5'd5, 32'h0000_BBBB, 32'hAAAA_AAAA, 32'h204, 32'h200));
    @(negedge clk);
    chk("B_we", rf_we, 8'h3C);
    @(negedge clk);
    sync();
    chk("B_rf5", rf_m[5], 32'hAAAA_BBBB);
    chk("A_rf3", rf_m[3], 32'h11);

    // Exception on lane 0.
    send(mk(2'b11, 2'b01, 8'hFF, 5'd7, 5'd6, 32'h77, 32'h66, 32'h1004, 32'h1000));
    @(negedge clk);
    chk("C_flush", ws_ex_flush, 1'b1);
    chk("C_epc", ws_epc, 32'h1000);
    chk("C_we", rf_we, 8'h00);
    chk("C_trace", {debug_wb_pc, debug_wb_rf_wen}, {32'h1000, 4'h0});
    chk("C_allowin", ws_allowin, 1'b1);
    @(negedge clk);
    chk("C_flush_c2", ws_ex_flush, 1'b0);
    sync();

    // Exception on lane 1: lane 0 still commits.
    send(mk(2'b11, 2'b10, 8'hFF, 5'd7, 5'd6, 32'h77, 32'h66, 32'h1104, 32'h1100));
    @(negedge clk);
    chk("C2_flush_epc", {ws_ex_flush, ws_epc}, {1'b1, 32'h1104});
    chk("C2_we", rf_we, 8'h0F);
    @(negedge clk);
    chk("C2_trace_c2", {debug_wb_pc, debug_wb_rf_wen}, {32'h1104, 4'h0});
    sync();
    chk("C_flush_cnt", flush_cnt, 2);
    chk("C2_rf6", rf_m[6], 32'h66);

    // Empty group.
    send(mk(2'b00, 2'b00, 8'hFF, 5'd9, 5'd8, 32'h99, 32'h88, 32'h2004, 32'h2000));
    @(negedge clk);
    chk("D_allowin", ws_allowin, 1'b1);
    chk("D_trace", debug_wb_pc, 32'h0);
    chk("D_we", rf_we, 8'h00);
    sync(); sync();

    // Back-to-back groups, R = 2, 1, 2, 1.
    acc_cyc.delete(); trace_log.delete();
    send(mk(2'b11, 2'b00, 8'hFF, 5'd11, 5'd10, 32'h31, 32'h30, 32'h304, 32'h300));
    send(mk(2'b01, 2'b00, 8'hFF, 5'd13, 5'd12, 32'h33, 32'h32, 32'h314, 32'h310));
    send(mk(2'b11, 2'b00, 8'h1F, 5'd14, 5'd14, 32'h35, 32'h34, 32'h324, 32'h320));
    send(mk(2'b10, 2'b00, 8'hFF, 5'd16, 5'd15, 32'h37, 32'h36, 32'h334, 32'h330));
    repeat (4) sync();
    chk("E_nacc", acc_cyc.size(), 4);
    if (acc_cyc.size() == 4) begin
      chk("E_gap01", acc_cyc[1] - acc_cyc[0], 2);
      chk("E_gap12", acc_cyc[2] - acc_cyc[1], 1);
      chk("E_gap23", acc_cyc[3] - acc_cyc[2], 2);
    end
    chk("E_ntrace", trace_log.size(), 6);
    if (trace_log.size() == 6)
      chk("E_trace_seq", {trace_log[0], trace_log[1], trace_log[2], trace_log[3], trace_log[4], trace_log[5]},
          {32'h300, 32'h304, 32'h310, 32'h320, 32'h324, 32'h334});
    chk("E_rf14", rf_m[14], 32'h35);

    // Reset during the second trace beat.
    trace_log.delete();
    send(mk(2'b11, 2'b00, 8'hFF, 5'd18, 5'd17, 32'h41, 32'h40, 32'h404, 32'h400));
    @(negedge clk);
    chk("F_trace_c1", debug_wb_pc, 32'h400);
    sync(); reset = 1'b1;
    @(negedge clk);
    chk("F_rst_trace", debug_wb_pc, 32'h0);
    chk("F_rst_allowin", ws_allowin, 1'b1);
    sync(); reset = 1'b0;
    @(negedge clk);
    chk("F_after_allowin", ws_allowin, 1'b1);
    chk("F_after_outs", {rf_we, debug_wb_pc, ws_to_ds_we}, '0);
    repeat (3) sync();
    chk("F_ntrace", trace_log.size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
